y86_seq_alu_cc: RTL and testbench
=================================

Name: y86_seq_alu_cc

Overview:
- Parametrised, multi-cycle successor to the combinational execute-stage ALU.
- Supports the four Y86 integer operations: ADD, SUB, AND and XOR.
- Computes the result in SLICE-bit chunks, least-significant chunk first, with the carry chained between cycles.
- Owns the architectural condition-code register (ZF, SF, OF), written on completion when enabled.
- Sits in the execute stage and talks to the sequencer over a start/busy/done handshake.

Parameters:
- WIDTH, 64: operand and result width in bits.
- SLICE, 16: bits processed per cycle. Must divide WIDTH exactly; otherwise elaboration fails.
- NSLICE = WIDTH/SLICE is derived, not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a new operation; sampled only when idle.
- op  in  2  operation: 00 ADD (x+y), 01 SUB (x-y), 10 AND, 11 XOR.
- x  in  WIDTH  operand X; sampled with start.
- y  in  WIDTH  operand Y; sampled with start.
- set_cc  in  1  when 1, this operation updates the CC register on completion; sampled with start.
- busy  out  1  1 while an operation is in progress.
- done  out  1  one-cycle pulse; z is valid from this cycle.
- z  out  WIDTH  result register; holds its value until the next completion.
- cc_zf  out  1  zero flag.
- cc_sf  out  1  sign flag.
- cc_of  out  1  signed-overflow flag.

Behaviour:
- Reset values while rst=1, applied asynchronously: state=IDLE, busy=0, done=0, z=0, cc_zf=1, cc_sf=0, cc_of=0. All internal latches and the slice counter are cleared.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge E0:
  - latch x, y, op and set_cc;
  - slice counter := 0;
  - carry := 1 if op=SUB, else 0;
  - go to RUN; busy=1 from E0.
- IDLE, start=0: no change.
- RUN, edge k (k = 1..NSLICE):
  - compute slice k-1 of the result;
  - ADD: x_s + y_s + carry. SUB: x_s + ~y_s + carry (two's complement). AND/XOR: bitwise, carry ignored;
  - store the slice into the working register and store the carry-out.
- RUN, edge NSLICE, final slice:
  - z := full working result;
  - done := 1 for exactly one cycle;
  - busy := 0; go to IDLE.
- Latency: done is high in the cycle after edge E0+NSLICE. Default is 4 edges after the start edge.
- start while busy=1 is ignored: no effect on operands, op or the FSM.
- start is accepted in the done cycle. Back-to-back throughput is one operation per NSLICE+1 cycles.
- CC update happens at the completion edge, only if the latched set_cc=1:
  - ZF = (z==0);
  - SF = z[WIDTH-1];
  - OF for ADD: x[W-1]==y[W-1] and z[W-1]!=x[W-1];
  - OF for SUB: x[W-1]!=y[W-1] and z[W-1]!=x[W-1];
  - OF for AND/XOR: 0.
- If set_cc=0, the CC register keeps its previous values.
- z and the CC outputs do not change during RUN. Intermediate slices are never visible on outputs.
- Arithmetic wraps modulo 2^WIDTH. The final carry-out is discarded and not exported.
- Reset mid-RUN aborts the operation: no done pulse, no z or CC update, and all outputs take their reset values.
- Operand or op changes after the start edge have no effect on the operation in flight.

Test Plan:
1. Signed overflow and latency: WIDTH=64, SLICE=16, ADD, x=0x7FFF_FFFF_FFFF_FFFF, y=1, set_cc=1 -> done exactly 4 edges after the start edge; z=0x8000_0000_0000_0000; ZF=0, SF=1, OF=1; busy high for 4 cycles.
2. Carry across slice boundaries: ADD x=0x0000_0000_FFFF_FFFF, y=1 -> z=0x0000_0001_0000_0000, OF=0. Then SUB x=5, y=5 -> z=0, ZF=1, SF=0, OF=0.
3. CC hold with set_cc=0:
   - first SUB x=0, y=1, set_cc=1 -> z=0xFFFF_FFFF_FFFF_FFFF, SF=1, OF=0;
   - then AND x=0, y=0xFF, set_cc=0 -> z=0, CC still ZF=0, SF=1, OF=0.
4. Handshake:
   - start XOR x=0xF0, y=0xFF, with start pulses every cycle while busy -> one result only, z=0x0F;
   - start ADD 2+3 in the done cycle -> accepted; second done 5 cycles after the first; z=5.
5. Reset mid-operation: start ADD 1+1, assert rst for one cycle at the second RUN edge -> busy=0, no done pulse, z=0, ZF=1, SF=0, OF=0. A subsequent ADD 1+1 gives z=2.
6. Parameter variant WIDTH=32, SLICE=32 (NSLICE=1): SUB x=0x8000_0000, y=1 -> z=0x7FFF_FFFF, OF=1, SF=0, ZF=0; done one edge after the start edge.

Source files
------------

// File: rtl/y86_seq_alu_cc.sv
// ---------------------------------------------------------------------------
// y86_seq_alu_cc
// Multi-cycle Y86 execute-stage ALU. It handles ADD, SUB, AND and XOR and
// works on SLICE bits per clock, starting with the least-significant slice.
// The carry passes from one cycle to the next. The block also holds the
// architectural condition codes (ZF, SF, OF). It talks to the sequencer
// through a start / busy / done handshake.
// ---------------------------------------------------------------------------
module y86_seq_alu_cc #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             set_cc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // The slicing only works when SLICE divides WIDTH with nothing left over.
    generate
        if ((SLICE <= 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
            $error("y86_seq_alu_cc: SLICE must divide WIDTH exactly");
        end
    endgenerate

    // FSM and latched operation context
    logic             r_state;
    logic [WIDTH-1:0] r_x;        // shifts right by SLICE bits after each slice
    logic [WIDTH-1:0] r_y;        // shifts right by SLICE bits after each slice
    logic [1:0]       r_op;
    logic             r_set_cc;
    logic             r_x_msb;    // original sign bits, kept for the OF flag
    logic             r_y_msb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_work;     // result slices enter here at the top

    // Registered outputs
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    // Datapath for the current slice
    logic [SLICE-1:0] w_x_s;
    logic [SLICE-1:0] w_y_s;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_slice;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_work_next;
    logic             w_last;
    logic             w_of;

    assign w_x_s = r_x[SLICE-1:0];
    assign w_y_s = r_y[SLICE-1:0];

    // Compute one result slice and its carry-out. Logic ops ignore the carry.
    always_comb begin
        w_sum       = '0;
        w_slice     = '0;
        w_carry_out = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_sum       = {1'b0, w_x_s} + {1'b0, w_y_s} + {{SLICE{1'b0}}, r_carry};
                w_slice     = w_sum[SLICE-1:0];
                w_carry_out = w_sum[SLICE];
            end
            OP_SUB: begin
                w_sum       = {1'b0, w_x_s} + {1'b0, ~w_y_s} + {{SLICE{1'b0}}, r_carry};
                w_slice     = w_sum[SLICE-1:0];
                w_carry_out = w_sum[SLICE];
            end
            OP_AND: begin
                w_slice     = w_x_s & w_y_s;
                w_carry_out = 1'b0;
            end
            OP_XOR: begin
                w_slice     = w_x_s ^ w_y_s;
                w_carry_out = 1'b0;
            end
            default: begin
                w_slice     = '0;
                w_carry_out = 1'b0;
            end
        endcase
    end

    // Insert the new slice at the top of the working register and shift the
    // older slices down. After NSLICE steps the first slice sits in bits [SLICE-1:0].
    assign w_work_next = (r_work >> SLICE) | (WIDTH'(w_slice) << (WIDTH - SLICE));

    assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

    // Signed overflow from the operand sign bits and the sign of the result
    always_comb begin
        w_of = 1'b0;
        case (r_op)
            OP_ADD:  w_of = (r_x_msb == r_y_msb) && (w_work_next[WIDTH-1] != r_x_msb);
            OP_SUB:  w_of = (r_x_msb != r_y_msb) && (w_work_next[WIDTH-1] != r_x_msb);
            default: w_of = 1'b0;
        endcase
    end

    // Sequencer: accept work when idle, step one slice per cycle, and on the
    // final slice publish z and the CC flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_op     <= 2'b00;
            r_set_cc <= 1'b0;
            r_x_msb  <= 1'b0;
            r_y_msb  <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_z      <= '0;
            r_zf     <= 1'b1;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x      <= x;
                        r_y      <= y;
                        r_op     <= op;
                        r_set_cc <= set_cc;
                        r_x_msb  <= x[WIDTH-1];
                        r_y_msb  <= y[WIDTH-1];
                        r_carry  <= (op == OP_SUB);
                        r_cnt    <= '0;
                        r_work   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_x     <= r_x >> SLICE;
                    r_y     <= r_y >> SLICE;
                    r_work  <= w_work_next;
                    r_carry <= w_carry_out;
                    if (w_last) begin
                        r_z     <= w_work_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        if (r_set_cc) begin
                            r_zf <= (w_work_next == '0);
                            r_sf <= w_work_next[WIDTH-1];
                            r_of <= w_of;
                        end else begin
                            r_zf <= r_zf;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign z     = r_z;
    assign cc_zf = r_zf;
    assign cc_sf = r_sf;
    assign cc_of = r_of;

endmodule

// File: tb/tb_y86_seq_alu_cc.sv
// ---------------------------------------------------------------------------
// Bench for y86_seq_alu_cc. Directed and random operations are checked
// against a math-level model that uses sign-extended 128-bit arithmetic.
// A second instance covers the single-slice configuration.
// ---------------------------------------------------------------------------
module tb_y86_seq_alu_cc;

    localparam int W   = 64;
    localparam int S   = 16;
    localparam int NS  = W / S;
    localparam int W2  = 32;
    localparam int S2  = 32;
    localparam int NS2 = W2 / S2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, set_cc, busy, done, cc_zf, cc_sf, cc_of;
    logic [1:0]    op;
    logic [W-1:0]  x, y, z;
    logic          start2, set_cc2, busy2, done2, cc_zf2, cc_sf2, cc_of2;
    logic [1:0]    op2;
    logic [W2-1:0] x2, y2, z2;

    y86_seq_alu_cc #(.WIDTH(W), .SLICE(S)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
        .set_cc(set_cc), .busy(busy), .done(done), .z(z),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of));

    y86_seq_alu_cc #(.WIDTH(W2), .SLICE(S2)) u_dut32 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .x(x2), .y(y2),
        .set_cc(set_cc2), .busy(busy2), .done(done2), .z(z2),
        .cc_zf(cc_zf2), .cc_sf(cc_sf2), .cc_of(cc_of2));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference architectural state for each instance
    logic [63:0] m_z,  m2_z;
    logic        m_zf, m_sf, m_of, m2_zf, m2_sf, m2_of;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] sext(input logic [63:0] v, input int w);
        logic [127:0] r;
        r = {64'd0, v};
        if (v[w-1]) r = r | ~((128'd1 << w) - 128'd1);
        return r;
    endfunction

    // Exact signed arithmetic; overflow means the true result does not fit in w bits
    function automatic void model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                  input int w, output logic [63:0] rz, output logic rzf,
                                  output logic rsf, output logic rof);
        logic [63:0]  mask;
        logic [127:0] sa, sb, s;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        sa = sext(a & mask, w);
        sb = sext(b & mask, w);
        case (o)
            2'd0:    s = sa + sb;
            2'd1:    s = sa - sb;
            2'd2:    s = sa & sb;
            default: s = sa ^ sb;
        endcase
        rz  = s[63:0] & mask;
        rzf = (rz == 64'd0);
        rsf = rz[w-1];
        rof = (o == 2'd0 || o == 2'd1) ? (sext(rz, w) != s) : 1'b0;
    endfunction

    task automatic check_cc64(input string tag);
        check_eq({tag, "_zf"}, 64'(cc_zf), 64'(m_zf));
        check_eq({tag, "_sf"}, 64'(cc_sf), 64'(m_sf));
        check_eq({tag, "_of"}, 64'(cc_of), 64'(m_of));
    endtask

    // Issue one operation on the 64-bit instance. The call starts #1 after a
    // clock edge and returns #1 after the edge that raised done.
    // With spam set, start stays high for the whole busy period.
    task automatic run64(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic sc, input bit spam);
        int lat;
        bit seen;
        logic [63:0] ez;
        logic ezf, esf, eof;
        check_eq("idle_before_start", 64'(busy), 64'd0);
        start = 1'b1; op = o; x = a; y = b; set_cc = sc;
        model(o, a, b, W, ez, ezf, esf, eof);
        @(posedge clk); #1;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        if (!spam) start = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            op = 2'($urandom); x = {$urandom, $urandom}; y = {$urandom, $urandom};
            set_cc = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check_eq("z_hold_run", z, m_z);
                check_eq("busy_run", 64'(busy), 64'd1);
            end
        end
        start = 1'b0;
        check_eq("done_seen", 64'(seen), 64'd1);
        check_eq("latency", 64'(lat), 64'(NS));
        m_z = ez;
        if (sc) begin m_zf = ezf; m_sf = esf; m_of = eof; end
        check_eq("z", z, m_z);
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_cc64("cc");
    endtask

    task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic sc);
        int lat;
        bit seen;
        logic [63:0] ez;
        logic ezf, esf, eof;
        start2 = 1'b1; op2 = o; x2 = a; y2 = b; set_cc2 = sc;
        model(o, {32'd0, a}, {32'd0, b}, W2, ez, ezf, esf, eof);
        @(posedge clk); #1;
        start2 = 1'b0;
        check_eq("w32_busy", 64'(busy2), 64'd1);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done2) seen = 1'b1;
        end
        check_eq("w32_done_seen", 64'(seen), 64'd1);
        check_eq("w32_latency", 64'(lat), 64'(NS2));
        m2_z = ez;
        if (sc) begin m2_zf = ezf; m2_sf = esf; m2_of = eof; end
        check_eq("w32_z", {32'd0, z2}, m2_z);
        check_eq("w32_zf", 64'(cc_zf2), 64'(m2_zf));
        check_eq("w32_sf", 64'(cc_sf2), 64'(m2_sf));
        check_eq("w32_of", 64'(cc_of2), 64'(m2_of));
    endtask

    initial begin
        int t1;
        logic [63:0] ra, rb;
        rst = 1'b1;
        start = 1'b0; op = 2'd0; x = '0; y = '0; set_cc = 1'b0;
        start2 = 1'b0; op2 = 2'd0; x2 = '0; y2 = '0; set_cc2 = 1'b0;
        m_z = 64'd0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m2_z = 64'd0; m2_zf = 1'b1; m2_sf = 1'b0; m2_of = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_z", z, 64'd0);
        check_cc64("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed overflow and latency
        run64(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
        check_eq("t1_z", z, 64'h8000_0000_0000_0000);
        check_eq("t1_of", 64'(cc_of), 64'd1);

        // Carry across slice boundaries, then a zero result
        run64(2'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
        check_eq("t2_z", z, 64'h0000_0001_0000_0000);
        run64(2'd1, 64'd5, 64'd5, 1'b1, 1'b0);
        check_eq("t2_zf", 64'(cc_zf), 64'd1);

        // CC registers hold when set_cc is 0
        run64(2'd1, 64'd0, 64'd1, 1'b1, 1'b0);
        check_eq("t3_z", z, 64'hFFFF_FFFF_FFFF_FFFF);
        run64(2'd2, 64'd0, 64'hFF, 1'b0, 1'b0);
        check_eq("t3_sf_held", 64'(cc_sf), 64'd1);
        check_eq("t3_zf_held", 64'(cc_zf), 64'd0);

        // start while busy is ignored; start in the done cycle is accepted
        run64(2'd3, 64'hF0, 64'hFF, 1'b1, 1'b1);
        check_eq("t4_z", z, 64'h0F);
        t1 = cyc;
        run64(2'd0, 64'd2, 64'd3, 1'b1, 1'b0);
        check_eq("t4_b2b_gap", 64'(cyc - t1), 64'(NS + 1));
        check_eq("t4_z2", z, 64'd5);
        @(posedge clk); #1;
        check_eq("t4_done_pulse", 64'(done), 64'd0);

        // Reset in the middle of an operation
        start = 1'b1; op = 2'd0; x = 64'd1; y = 64'd1; set_cc = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        m_z = 64'd0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m2_z = 64'd0; m2_zf = 1'b1; m2_sf = 1'b0; m2_of = 1'b0;
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_z", z, 64'd0);
        check_cc64("t5");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NS + 2; i++) begin
            @(posedge clk); #1;
            check_eq("t5_no_done", 64'(done), 64'd0);
        end
        run64(2'd0, 64'd1, 64'd1, 1'b1, 1'b0);
        check_eq("t5_z_after", z, 64'd2);

        // Random operations with mixed corner-case operands
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       ra = 64'h7FFF_FFFF_FFFF_FFFF;
                1:       ra = 64'h8000_0000_0000_0000;
                2:       rb = ra;
                default: ra = ra;
            endcase
            run64(2'($urandom), ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Single-slice configuration
        run32(2'd1, 32'h8000_0000, 32'd1, 1'b1);
        check_eq("t6_z", {32'd0, z2}, 64'h7FFF_FFFF);
        check_eq("t6_of", 64'(cc_of2), 64'd1);
        for (int i = 0; i < 10; i++) begin
            run32(2'($urandom), $urandom, $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
